// File: rtl/gpio_link_pkg.sv
// Shared definitions for the FPGA<->Arduino GPIO link: command codes,
// payload field widths and the transmit FSM state encoding.
package gpio_link_pkg;

  localparam logic [1:0] CMD_LOBBY     = 2'b00;
  localparam logic [1:0] CMD_TARGET    = 2'b01;
  localparam logic [1:0] CMD_HIT_ACK   = 2'b10;
  localparam logic [1:0] CMD_GAME_OVER = 2'b11;

  localparam int PAYLOAD_W = 8;
  localparam int SEQ_W     = 3;
  localparam int BOX_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/arduino_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and emits a
// one-cycle tick on the last count; clear restarts the bit period.
module arduino_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/arduino_cmd_tx.sv
// Game-command transmitter: serializes {cmd, box, seq} as an 8N1 frame on one
// GPIO_1 pin. Define ARDUINO_CMD_TX_PARITY_EN to add an odd-parity bit.
module arduino_cmd_tx
  import gpio_link_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             tx_valid,
  input  logic [1:0]       tx_cmd,
  input  logic [BOX_W-1:0] tx_box,
  output logic             tx_ready,
  output logic             tx_done,
  output logic             tx_line,
  output logic [SEQ_W-1:0] tx_seq
);

  tx_state_t            state_q, state_d;
  logic [2:0]           bit_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [SEQ_W-1:0]     seq_q;
  logic                 tick;
  logic                 accept;
  logic                 line_d;
  logic                 done_d;

  assign accept = tx_valid && (state_q == ST_IDLE);

  arduino_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clear    (accept),
    .en       (state_q != ST_IDLE),
    .tick     (tick)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    line_d  = 1'b1;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_START;
      end
      ST_START: begin
        line_d = 1'b0;
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        line_d = payload_q[bit_q];
        if (tick && (bit_q == 3'd7)) begin
`ifdef ARDUINO_CMD_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef ARDUINO_CMD_TX_PARITY_EN
      ST_PARITY: begin
        line_d = ~^payload_q;
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        line_d = 1'b1;
        if (tick) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Payload and sequence are captured only at acceptance; later input changes are ignored.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      payload_q <= '0;
      seq_q     <= '0;
      bit_q     <= '0;
    end else if (accept) begin
      payload_q <= {tx_cmd, tx_box, seq_q + SEQ_W'(1)};
      seq_q     <= seq_q + SEQ_W'(1);
      bit_q     <= '0;
    end else if ((state_q == ST_DATA) && tick) begin
      bit_q <= bit_q + 3'd1;
    end
  end

  assign tx_line  = line_d;
  assign tx_done  = done_d;
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_seq   = seq_q;

endmodule

// File: tb/tb_arduino_cmd_tx.sv
// Self-checking bench for arduino_cmd_tx with CLKS_PER_BIT=4: a frame-timeline
// model checked every cycle, plus directed literal checks.
module tb_arduino_cmd_tx;

  localparam int CPB = 4;
`ifdef ARDUINO_CMD_TX_PARITY_EN
  localparam int NBITS   = 11;
  localparam int DONE_AT = 44;
`else
  localparam int NBITS   = 10;
  localparam int DONE_AT = 40;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b1;
  logic       tx_valid = 1'b0;
  logic [1:0] tx_cmd   = 2'b00;
  logic [2:0] tx_box   = 3'b000;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_line;
  logic [2:0] tx_seq;

  int checks = 0;
  int errors = 0;

  arduino_cmd_tx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .tx_valid (tx_valid),
    .tx_cmd   (tx_cmd),
    .tx_box   (tx_box),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .tx_line  (tx_line),
    .tx_seq   (tx_seq)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: after acceptance, cycle k (1..FLEN) of the frame shows frame bit (k-1)/CPB.
  bit         m_busy = 1'b0;
  int         m_k    = 0;
  logic [2:0] m_seq  = 3'd0;
  logic [7:0] m_byte = 8'h00;
  logic       m_frame [0:10];
  logic       e_line, e_ready, e_done;

  function automatic logic odd_parity(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) if (b[i]) n++;
    return (n % 2 == 0);
  endfunction

  always @(negedge CLOCK_50) begin
    if (!resetn) begin
      m_busy  = 1'b0;
      m_seq   = 3'd0;
      e_line  = 1'b1;
      e_ready = 1'b1;
      e_done  = 1'b0;
    end else if (m_busy) begin
      m_k++;
      e_line  = m_frame[(m_k - 1) / CPB];
      e_ready = 1'b0;
      e_done  = (m_k == FLEN);
    end else begin
      e_line  = 1'b1;
      e_ready = 1'b1;
      e_done  = 1'b0;
    end
    chk("line",  tx_line,  e_line);
    chk("ready", tx_ready, e_ready);
    chk("done",  tx_done,  e_done);
    chk("seq",   tx_seq,   m_seq);
    if (resetn) begin
      if (m_busy && m_k == FLEN) begin
        m_busy = 1'b0;
      end else if (!m_busy && tx_valid) begin
        m_seq++;
        m_byte     = {tx_cmd, tx_box, m_seq};
        m_frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_frame[1 + i] = m_byte[i];
`ifdef ARDUINO_CMD_TX_PARITY_EN
        m_frame[9]  = odd_parity(m_byte);
        m_frame[10] = 1'b1;
`else
        m_frame[9]  = 1'b1;
        m_frame[10] = 1'b1;
`endif
        m_busy = 1'b1;
        m_k    = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      cyc(1);
      if (tx_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   exp1 [11] = '{0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 1};
    int   exp_seq [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int   ndone;
    bit   ok;
    logic [7:0] got;
    int   cur;

    // Reset state
    #1 resetn = 1'b0;
    cyc(3);
    resetn = 1'b1;
    cyc(1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_line",  tx_line,  1);
    chk("rst_seq",   tx_seq,   0);
    chk("rst_done",  tx_done,  0);

    // Single TARGET box 5 frame: payload 0x69
    tx_valid = 1'b1; tx_cmd = 2'b01; tx_box = 3'd5;
    cyc(1);
    tx_valid = 1'b0;
    chk("t1_model_byte", m_byte, 8'h69);
    ndone = 0;
    for (int k = 1; k <= FLEN; k++) begin
      if ((k - 1) % CPB == 1) chk("t1_bit", tx_line, exp1[(k - 1) / CPB]);
      if (tx_done) begin
        ndone++;
        chk("t1_done_cycle", k, DONE_AT);
      end
      if (k < FLEN) cyc(1);
    end
    chk("t1_done_count", ndone, 1);
    cyc(1);
    chk("t1_ready", tx_ready, 1);
    chk("t1_seq",   tx_seq,   1);

    // Back-to-back: 9 frames with tx_valid held high
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
    tx_valid = 1'b1; tx_cmd = 2'b10; tx_box = 3'd3;
    for (int f = 0; f < 9; f++) begin
      wait_done(FLEN + 5, ok);
      chk("t2_done_seen", ok, 1);
      if (!ok) break;
      chk("t2_seq", tx_seq, exp_seq[f]);
      if (f == 8) begin
        tx_valid = 1'b0;
      end else begin
        cyc(1);
        chk("t2_gap_line",  tx_line,  1);
        chk("t2_gap_ready", tx_ready, 1);
        cyc(1);
        chk("t2_start_line", tx_line, 0);
      end
    end
    cyc(3);
    chk("t2_no_extra", tx_ready, 1);
    chk("t2_final_seq", tx_seq, 1);

    // Inputs changed mid-frame are ignored: expect {11,000,010} = 0xC2
    tx_valid = 1'b1; tx_cmd = 2'b11; tx_box = 3'd0;
    cyc(1);
    tx_valid = 1'b0;
    cur = 1;
    for (int i = 0; i < 8; i++) begin
      cyc(CPB * (i + 1) + 2 - cur);
      cur = CPB * (i + 1) + 2;
      got[i] = tx_line;
      if (i == 2) begin
        tx_cmd = 2'b00; tx_box = 3'd7;
      end
    end
    chk("t3_byte", got, 8'hC2);
    wait_done(FLEN, ok);
    chk("t3_done_seen", ok, 1);

    // Reset during data bit 4
    cyc(1);
    tx_valid = 1'b1; tx_cmd = 2'b01; tx_box = 3'd2;
    cyc(1);
    tx_valid = 1'b0;
    cyc(20);
    resetn = 1'b0;
    #1;
    chk("t4_line",  tx_line,  1);
    chk("t4_ready", tx_ready, 1);
    chk("t4_seq",   tx_seq,   0);
    chk("t4_done",  tx_done,  0);
    cyc(2);
    resetn = 1'b1;
    wait_done(FLEN + 10, ok);
    chk("t4_no_done", ok, 0);
    tx_valid = 1'b1; tx_cmd = 2'b00; tx_box = 3'd4;
    cyc(1);
    tx_valid = 1'b0;
    chk("t4_next_seq", tx_seq, 1);
    wait_done(FLEN + 5, ok);
    chk("t4_next_done", ok, 1);

    // tx_valid while busy is not queued
    cyc(1);
    tx_valid = 1'b1; tx_cmd = 2'b00; tx_box = 3'd1;
    cyc(1);
    cyc(10);
    tx_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < FLEN + 5; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    chk("t5_ready_back", ok, 1);
    cyc(10);
    chk("t5_still_idle", tx_ready, 1);
    chk("t5_line_high",  tx_line,  1);
    chk("t5_seq",        tx_seq,   2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arduino_cmd_tx.md
Name: arduino_cmd_tx

Overview:
- Transmit side of the FPGA↔Arduino GPIO link; the sensor path is the receive side.
- Serializes game commands (light target box, confirm hit, lobby, game over) into 8N1 frames on one GPIO_1 output pin.
- Sits between the game datapath (command source, valid/ready handshake) and the GPIO_1 header.

Parameters:
- CLK_HZ, 50000000, CLOCK_50 frequency in Hz.
- BAUD, 115200, line bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer division, =434), cycles per line bit; overridable for simulation; must be ≥2.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- tx_valid  in  1  command present.
- tx_cmd  in  2  00 LOBBY, 01 TARGET, 10 HIT_ACK, 11 GAME_OVER.
- tx_box  in  3  box address 0..7 (ignored by Arduino for LOBBY/GAME_OVER, still sent).
- tx_ready  out  1  high only in IDLE; a frame is accepted on a cycle with tx_valid & tx_ready.
- tx_done  out  1  one-cycle pulse on the last cycle of the stop bit.
- tx_line  out  1  serial output to GPIO_1 pin; idle high.
- tx_seq  out  3  sequence number of the last accepted frame.

Behaviour:
- Reset (async, resetn=0): state IDLE, tx_line=1, tx_ready=1, tx_done=0, tx_seq=0, bit/baud counters 0. Reset mid-frame aborts it; tx_line returns high immediately; no tx_done.
- Payload byte = {tx_cmd[1:0], tx_box[2:0], seq[2:0]}, with seq = tx_seq+1 mod 8 at acceptance. tx_seq updates on the acceptance cycle; it wraps 7→0.
- Inputs are latched on acceptance. Changes to tx_cmd/tx_box during a frame are ignored.
- FSM states:
  - IDLE: tx_line=1, tx_ready=1. On acceptance → START next cycle.
  - START: tx_line=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit index 0..7; after bit 7 → STOP (or PARITY if enabled).
  - STOP: tx_line=1 for CLKS_PER_BIT cycles; tx_done pulses on its final cycle → IDLE.
- Latency: tx_line falls on the cycle after acceptance. A frame occupies exactly 10*CLKS_PER_BIT cycles (11* with parity).
- Back-to-back: with tx_valid held high, the next acceptance occurs in the first IDLE cycle after STOP. This guarantees ≥1 idle-high cycle between frames.
- tx_ready is registered; it deasserts the cycle after acceptance.
- tx_valid while not ready: no effect, no queuing.
- The baud counter counts 0..CLKS_PER_BIT-1, then wraps; the bit advances on wrap.

Optional Feature:
- Macro: ARDUINO_CMD_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the odd parity of the 8 payload bits (XOR of payload inverted) for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state; 10-bit frame.

Decomposition:
- Package gpio_link_pkg:
  - cmd constants CMD_LOBBY=2'b00, CMD_TARGET=2'b01, CMD_HIT_ACK=2'b10, CMD_GAME_OVER=2'b11.
  - state encoding; PAYLOAD_W=8, SEQ_W=3, BOX_W=3.
- One sub-module, arduino_baud_tick: parameterized counter with clear input and one-cycle tick output at CLKS_PER_BIT. The FSM clears it on acceptance.

Test Plan (CLKS_PER_BIT=4):
- Reset, then tx_valid=1, cmd=01, box=5 for one cycle → payload 0x69 (seq=1). tx_line sequence per 4 cycles: 0 | 1,0,0,1,0,1,1,0 | 1. tx_done at cycle 40 after acceptance, tx_seq=1.
- tx_valid held high, cmd=10, box=3, for 9 frames → tx_seq goes 1..7,0,1. Exactly one high idle cycle between stop and next start. 9 tx_done pulses.
- Accept cmd=11, box=0, then change tx_cmd/tx_box mid-DATA → serialized byte stays {11,000,seq}.
- resetn low at frame bit 4 → tx_line=1 immediately, tx_ready=1, tx_seq=0, no tx_done. The next accepted frame carries seq=1.
- tx_valid asserted while busy for 10 cycles, then dropped before IDLE → no second frame; tx_ready returns 1.
- With ARDUINO_CMD_TX_PARITY_EN, cmd=01, box=5 (0x69, four ones) → parity bit 1, frame 44 cycles, tx_done at cycle 44.
